// File: rtl/led_anim_pkg.sv
// Shared types and helpers for the LED animation sequencer: pattern modes,
// frame lengths and the pattern generator.
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_BAR    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Patterns are built at this width and cut down to the LED bank width.
  localparam int MAX_W = 64;

  function automatic int unsigned frame_len(input mode_e m, input int unsigned w);
    case (m)
      MODE_BAR:    return 2 * w;
      MODE_CHASE:  return w;
      MODE_BOUNCE: return 2 * w - 2;
      default:     return 2;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] pattern(input mode_e m, input int unsigned p,
                                               input int unsigned w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    pattern = '0;
    case (m)
      MODE_BAR:    pattern = (p < w) ? (one << (p + 1)) - one : (one << (2 * w - 1 - p)) - one;
      MODE_CHASE:  pattern = one << p;
      MODE_BOUNCE: pattern = (p < w) ? (one << p) : (one << (2 * w - 2 - p));
      default:     pattern = (p == 0) ? '1 : '0;
    endcase
  endfunction

endpackage

// File: rtl/led_anim_tick.sv
// Programmable prescaler: emits a one-cycle tick every period+1 enabled clocks.
// clear restarts the count regardless of en and suppresses the tick.
module led_anim_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= so that a period lowered below the running count fires right away.
  assign tick = en && !clear && (cnt >= period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt >= period) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_anim_seq.sv
// LED animation sequencer: BAR / CHASE / BOUNCE / BLINK patterns stepped by a
// prescaler. Optional PWM dimming is enabled with the LED_ANIM_PWM_EN macro.
module led_anim_seq
  import led_anim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
`ifdef LED_ANIM_PWM_EN
  input  logic [3:0]       duty,
`endif
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             frame_done
);

  localparam int POS_W = $clog2(2 * WIDTH);

  mode_e            mode_q;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] last;
  logic             restart;
  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] pat;

  assign restart = (mode_e'(mode) != mode_q);
  assign last    = POS_W'(frame_len(mode_q, WIDTH) - 1);
  assign wrap    = (pos >= last);
  assign pat     = WIDTH'(pattern(mode_q, 32'(pos), WIDTH));

  led_anim_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clear  (restart),
    .period (period),
    .tick   (tick)
  );

`ifdef LED_ANIM_PWM_EN
  logic [3:0] pwm;
  logic       lit;

  assign lit = (duty == 4'hF) || (pwm < duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 4'd0;
    else     pwm <= pwm + 4'd1;
  end
`endif

  // out follows (mode_q, pos) one clock later; step/frame_done align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_BAR;
      pos        <= '0;
      out        <= '0;
      step       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mode_q     <= mode_e'(mode);
      step       <= tick;
      frame_done <= tick && wrap;
`ifdef LED_ANIM_PWM_EN
      out        <= pat & {WIDTH{lit}};
`else
      out        <= pat;
`endif
      if (restart) begin
        pos <= '0;
      end else if (tick) begin
        pos <= wrap ? '0 : pos + POS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_anim_seq.sv
// Directed plus randomized bench for led_anim_seq, checked against a frame-table
// reference model.
module tb_led_anim_seq;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] period;
  logic [W-1:0]  out;
  logic          step;
  logic          frame_done;
`ifdef LED_ANIM_PWM_EN
  logic [3:0]    duty = 4'hF;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one table of LED values per mode, plus step timing.
  logic [W-1:0] tbl[4][16];
  int           len[4];
  int           m_mode;
  int           m_idx;
  int           m_since;
  logic [W-1:0] exp_q[$];
  logic         exp_step;
  logic         exp_fd;

  always #5 clk = ~clk;

  led_anim_seq #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .period     (period),
`ifdef LED_ANIM_PWM_EN
    .duty       (duty),
`endif
    .out        (out),
    .step       (step),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_tables();
    int v;
    for (int k = 1; k <= W; k++) begin
      v = (1 << k) - 1;
      tbl[0][k-1] = W'(v);
    end
    for (int k = W - 1; k >= 0; k--) begin
      v = (1 << k) - 1;
      tbl[0][W + (W - 1 - k)] = W'(v);
    end
    len[0] = 2 * W;
    for (int k = 0; k < W; k++) tbl[1][k] = W'(1 << k);
    len[1] = W;
    for (int k = 0; k < W; k++) tbl[2][k] = W'(1 << k);
    for (int k = 1; k <= W - 2; k++) tbl[2][W + k - 1] = W'(1 << (W - 1 - k));
    len[2] = 2 * W - 2;
    tbl[3][0] = '1;
    tbl[3][1] = '0;
    len[3] = 2;
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_idx   = 0;
    m_since = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit tk;
    exp_q.push_back(tbl[m_mode][m_idx]);
    if (int'(mode) != m_mode) begin
      exp_step = 1'b0;
      exp_fd   = 1'b0;
      m_idx    = 0;
      m_since  = 0;
    end else begin
      tk       = en && (m_since >= int'(period));
      exp_step = tk;
      exp_fd   = tk && (m_idx == len[m_mode] - 1);
      if (en) m_since = tk ? 0 : m_since + 1;
      if (tk) m_idx = (m_idx + 1) % len[m_mode];
    end
    m_mode = int'(mode);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, "_out"}, out, exp_q.pop_front());
    check({tag, "_step"}, W'(step), W'(exp_step));
    check({tag, "_frame_done"}, W'(frame_done), W'(exp_fd));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out"}, out, '0);
    check({tag, "_step"}, W'(step), '0);
    check({tag, "_frame_done"}, W'(frame_done), '0);
  endtask

  initial begin
    build_tables();
    rst    = 1'b1;
    en     = 1'b0;
    mode   = 2'd0;
    period = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    model_reset();

    // Full BAR frame at one step per clock, including the wrap pulse.
    en = 1'b1;
    run(20, "bar_p0");

    // CHASE stepping every 4 clocks.
    mode   = 2'd1;
    period = 16'd3;
    run(40, "chase_p3");

    // BOUNCE with no repeated endpoints.
    mode   = 2'd2;
    period = '0;
    run(30, "bounce_p0");

    // Switch from BAR mid-frame to BLINK.
    mode = 2'd0;
    for (int i = 0; i < 40 && !(m_mode == 0 && m_idx == 5); i++) cycle("bar_seek");
    mode = 2'd3;
    run(10, "bar_to_blink");

    // Period reduced below the running count, then an en=0 hold.
    mode   = 2'd1;
    period = 16'd100;
    run(50, "chase_p100");
    period = 16'd10;
    run(30, "chase_p10");
    en = 1'b0;
    run(20, "hold");
    en = 1'b1;
    run(20, "resume");

    // One-cycle reset mid-frame.
    rst = 1'b1;
    #1;
    check_zero("midrst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("midrst_held");
    rst = 1'b0;
    run(20, "after_rst");

    // Randomized modes, periods and enable.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) period = DW'($urandom_range(0, 5));
      en = ($urandom_range(0, 9) != 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_anim_seq.md
Name: led_anim_seq

Overview:
- Parametrised LED animation sequencer for WIDTH-bit LED banks.
- An internal programmable prescaler generates step ticks. A position counter walks through one of four selectable patterns: bar fill/drain, chase, bounce, blink.
- Drives the board LED outputs directly; sits beside the other display blocks under the top-level clock.

Parameters:
- WIDTH, 8, number of LED outputs (>=2).
- DIV_W, 16, width of the prescaler period input/counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes prescaler, position and out.
- mode  input  2  pattern select: 0 BAR, 1 CHASE, 2 BOUNCE, 3 BLINK.
- period  input  DIV_W  clocks per step minus one (0 = step every cycle).
- out  output  WIDTH  registered LED pattern.
- step  output  1  one-cycle pulse on every step tick.
- frame_done  output  1  one-cycle pulse when position wraps to 0.

Behaviour:
- Reset (async): prescaler cnt=0, pos=0, out=0, step=0, frame_done=0, mode_q=0.
- Prescaler, when en=1:
  - if cnt>=period: tick=1, cnt<=0; else cnt<=cnt+1.
  - The >= rule means a period reduced mid-count ticks on the next cycle.
- Frame length L(mode): BAR=2*WIDTH, CHASE=WIDTH, BOUNCE=2*WIDTH-2, BLINK=2.
- pos width: clog2(2*WIDTH). On tick: pos<=(pos==L-1)?0:pos+1. frame_done=1 on the same tick that pos wraps.
- Patterns, as a function of p=pos:
  - BAR: p<WIDTH -> (1<<(p+1))-1; p>=WIDTH -> (1<<(2*WIDTH-1-p))-1. WIDTH=8 sequence: 01,03,…,FF,7F,…,01,00.
  - CHASE: 1<<p.
  - BOUNCE: p<WIDTH -> 1<<p; else 1<<(2*WIDTH-2-p).
  - BLINK: p=0 -> all ones; p=1 -> all zeros.
- Latency: out<=pattern(mode_q,pos) every cycle, so out lags pos by exactly one clock. First valid out is one cycle after reset deasserts.
- step and frame_done are registered, asserted in the cycle after the tick, aligned with the out change.
- Mode change: mode_q registers mode. When mode!=mode_q, in that cycle: pos<=0, cnt<=0, no tick, frame_done not asserted. The new pattern at pos 0 appears on the following cycle. The restart applies even with en=0.
- en=0: cnt, pos, out, step/frame_done all hold at 0 pulses. Resumption continues from the held cnt.
- Reset mid-frame: immediate return to reset values; no partial pulse.
- Simultaneous mode change and tick: the mode restart wins.

Optional Feature:
- Macro: LED_ANIM_PWM_EN.
- Defined:
  - Adds input duty[3:0] and a free-running 4-bit pwm counter (reset 0, always counts, independent of en).
  - out = pattern & {WIDTH{(duty==4'hF) | (pwm<duty)}}. duty=0 gives dark, 15 gives full on.
  - Gating is applied in the out register, so out latency is unchanged.
- Undefined: no duty port and no pwm counter; out is the raw pattern.

Decomposition:
- led_anim_pkg:
  - mode enum (MODE_BAR, MODE_CHASE, MODE_BOUNCE, MODE_BLINK).
  - Frame-length function.
  - Pattern function pattern(mode,pos,WIDTH).
- Sub-module led_anim_tick (DIV_W): prescaler with en/clear inputs and tick output; reusable by other display blocks.

Test Plan:
- WIDTH=8, period=0, mode=BAR, en=1 after reset -> out 01,03,07,0F,1F,3F,7F,FF,7F,3F,1F,0F,07,03,01,00 on consecutive cycles; frame_done pulses with 00→01 wrap.
- period=3, mode=CHASE -> out changes every 4 clocks: 01,02,04…80,01; step pulses once per 4 clocks.
- mode=BOUNCE, period=0 -> 01,02,…,80,40,…,02,01 (14-step frame), no repeated endpoints.
- Mid-frame BAR pos=5: switch mode to BLINK -> pos restarts; out=FF on the second cycle after the switch, then 00, alternating.
- period=100, cnt≈50, drop period to 10 -> step on the next cycle, then every 11 clocks; en=0 for 20 cycles holds out and suppresses step.
- Assert rst mid-frame for 1 cycle -> out=00 immediately, then pattern restarts at pos 0. With LED_ANIM_PWM_EN, duty=4: each LED is on 4 of every 16 cycles.
